// File: rtl/cacheline_mem_arbiter_pkg.sv
// Shared types for the I/D cacheline memory arbiter: FSM state, grant source
// and a small state-decode helper.
package cacheline_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GNT_I,
    ARB_GNT_D,
    ARB_RELEASE
  } arb_state_t;

  typedef enum logic {
    ARB_SRC_I,
    ARB_SRC_D
  } arb_src_t;

  function automatic logic arb_is_gnt(input arb_state_t s);
    return (s == ARB_GNT_I) || (s == ARB_GNT_D);
  endfunction

endpackage

// File: rtl/cacheline_mem_arbiter_watchdog.sv
// Saturating cycle counter for a granted memory transaction with a sticky
// timeout flag; it only reports a hang and never aborts the transaction.
module cacheline_mem_arbiter_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic resp,
  output logic timeout
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      timeout <= 1'b0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !resp && (count != LIMIT)) begin
      count <= count + CW'(1);
      if ((count + CW'(1)) == LIMIT) timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/cacheline_mem_arbiter.sv
// Arbitrates the single cacheline-adaptor port between I-cache and D-cache
// misses, one line transaction at a time. Define ARB_RR_EN for round-robin.
module cacheline_mem_arbiter
  import cacheline_mem_arbiter_pkg::*;
#(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              arb_busy,
  output logic              arb_timeout,
  output arb_state_t        dbg_state
);

  // Handshake: requests are levels held until their 1-cycle x_resp pulse;
  // x_rdata is only meaningful in the cycle x_resp is high.

  arb_state_t state;
  logic       i_req;
  logic       d_req;
  logic       pick_d;
  logic       start;

`ifdef ARB_RR_EN
  arb_src_t last_gnt;
`endif

  always_comb begin
    i_req = i_read;
    d_req = d_read | d_write;
    start = (state == ARB_IDLE) && (i_req || d_req);
`ifdef ARB_RR_EN
    pick_d = d_req && (!i_req || (last_gnt == ARB_SRC_I));
`else
    pick_d = d_req;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      pmem_addr  <= '0;
      pmem_wdata <= '0;
`ifdef ARB_RR_EN
      last_gnt   <= ARB_SRC_I;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_d) begin
            state      <= ARB_GNT_D;
            pmem_addr  <= d_addr;
            pmem_wdata <= d_wdata;
            // An illegal read+write request resolves as a write-back.
            pmem_write <= d_write;
            pmem_read  <= !d_write;
`ifdef ARB_RR_EN
            last_gnt   <= ARB_SRC_D;
`endif
          end else if (i_req) begin
            state      <= ARB_GNT_I;
            pmem_addr  <= i_addr;
            pmem_read  <= 1'b1;
            pmem_write <= 1'b0;
`ifdef ARB_RR_EN
            last_gnt   <= ARB_SRC_I;
`endif
          end
        end
        ARB_GNT_I, ARB_GNT_D: begin
          if (pmem_resp) begin
            state      <= ARB_RELEASE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        ARB_RELEASE: state <= ARB_IDLE;
        default:     state <= ARB_IDLE;
      endcase
    end
  end

  assign i_rdata   = pmem_rdata;
  assign d_rdata   = pmem_rdata;
  assign i_resp    = (state == ARB_GNT_I) && pmem_resp;
  assign d_resp    = (state == ARB_GNT_D) && pmem_resp;
  assign arb_busy  = (state != ARB_IDLE);
  assign dbg_state = state;

  cacheline_mem_arbiter_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_arb_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start),
    .enable (arb_is_gnt(state)),
    .resp   (pmem_resp),
    .timeout(arb_timeout)
  );

  a_no_read_and_write: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write));

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Directed bench for cacheline_mem_arbiter: a cycle table for the basic
// transactions plus hand sequences for write latching, reset, watchdog and contention.
module tb_cacheline_mem_arbiter;
  import cacheline_mem_arbiter_pkg::*;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] I_ADDR = 32'h0000_0060;
  localparam logic [ADDR_W-1:0] D_ADDR = 32'h0000_0080;
  localparam logic [LINE_W-1:0] RDATA  = {32{8'hA5}};
  localparam logic [LINE_W-1:0] WDATA_A = {8{32'h1234_5678}};
  localparam logic [LINE_W-1:0] WDATA_B = {8{32'hDEAD_BEEF}};

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_read, d_read, d_write, pmem_resp;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LINE_W-1:0] d_wdata, pmem_rdata;
  logic [LINE_W-1:0] i_rdata, d_rdata, pmem_wdata;
  logic [ADDR_W-1:0] pmem_addr;
  logic              i_resp, d_resp, pmem_read, pmem_write, arb_busy, arb_timeout;
  arb_state_t        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Clock / reset
  always #5 clk = ~clk;

  cacheline_mem_arbiter #(
    .LINE_W(LINE_W), .ADDR_W(ADDR_W), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .arb_busy(arb_busy), .arb_timeout(arb_timeout), .dbg_state(dbg_state)
  );

  typedef struct {
    logic       ir, dr, dw, pr;
    arb_state_t st;
    logic       rd, wr, iresp, dresp;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl[NV];
  logic [0:0] exp_q[$];

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input string name);
    int w;
    w = 0;
    while (!arb_is_gnt(dbg_state) && w < 10) begin
      tick();
      w++;
    end
    chk(name, LINE_W'(arb_is_gnt(dbg_state)), LINE_W'(1));
  endtask

  initial begin
    logic [0:0] exp_src;
    logic [0:0] got_src;

    // I read (5-cycle adaptor), stray resp in IDLE and RELEASE, D read gap, D write
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, ARB_IDLE,    1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, ARB_GNT_I,   1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, ARB_GNT_I,   1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, ARB_GNT_I,   1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, ARB_GNT_I,   1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, ARB_GNT_I,   1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, ARB_RELEASE, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, ARB_IDLE,    1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, ARB_IDLE,    1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, ARB_IDLE,    1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, ARB_IDLE,    1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, ARB_GNT_D,   1'b1, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, ARB_RELEASE, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, ARB_IDLE,    1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, ARB_GNT_D,   1'b1, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, ARB_GNT_D,   1'b1, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, ARB_RELEASE, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, ARB_IDLE,    1'b0, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b0, ARB_IDLE,    1'b0, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b0, ARB_GNT_D,   1'b0, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 1'b1, 1'b1, ARB_GNT_D,   1'b0, 1'b1, 1'b0, 1'b1};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, ARB_RELEASE, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b0, ARB_IDLE,    1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    i_addr = I_ADDR; d_addr = D_ADDR; d_wdata = '0; pmem_rdata = RDATA;
    #12;
    chk("rst_state", LINE_W'(dbg_state), LINE_W'(ARB_IDLE));
    chk("rst_pmem_read", LINE_W'(pmem_read), '0);
    chk("rst_pmem_write", LINE_W'(pmem_write), '0);
    chk("rst_pmem_addr", LINE_W'(pmem_addr), '0);
    chk("rst_pmem_wdata", pmem_wdata, '0);
    chk("rst_busy", LINE_W'(arb_busy), '0);
    chk("rst_timeout", LINE_W'(arb_timeout), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      i_read = tbl[k].ir; d_read = tbl[k].dr; d_write = tbl[k].dw; pmem_resp = tbl[k].pr;
      #1;
      chk($sformatf("v%0d_state", k), LINE_W'(dbg_state), LINE_W'(tbl[k].st));
      chk($sformatf("v%0d_pmem_read", k), LINE_W'(pmem_read), LINE_W'(tbl[k].rd));
      chk($sformatf("v%0d_pmem_write", k), LINE_W'(pmem_write), LINE_W'(tbl[k].wr));
      chk($sformatf("v%0d_i_resp", k), LINE_W'(i_resp), LINE_W'(tbl[k].iresp));
      chk($sformatf("v%0d_d_resp", k), LINE_W'(d_resp), LINE_W'(tbl[k].dresp));
      chk($sformatf("v%0d_busy", k), LINE_W'(arb_busy), LINE_W'(tbl[k].st != ARB_IDLE));
      if (tbl[k].st == ARB_GNT_I) chk($sformatf("v%0d_addr", k), LINE_W'(pmem_addr), LINE_W'(I_ADDR));
      if (tbl[k].st == ARB_GNT_D) chk($sformatf("v%0d_addr", k), LINE_W'(pmem_addr), LINE_W'(D_ADDR));
      if (tbl[k].iresp) chk($sformatf("v%0d_i_rdata", k), i_rdata, RDATA);
      if (tbl[k].dresp) chk($sformatf("v%0d_d_rdata", k), d_rdata, RDATA);
      tick();
    end

    // Write-back data is latched at grant
    d_write = 1'b1; d_wdata = WDATA_A;
    tick();
    chk("wb_pmem_write", LINE_W'(pmem_write), LINE_W'(1));
    chk("wb_pmem_read", LINE_W'(pmem_read), '0);
    chk("wb_wdata", pmem_wdata, WDATA_A);
    d_wdata = WDATA_B;
    tick();
    chk("wb_wdata_held", pmem_wdata, WDATA_A);
    chk("wb_addr_held", LINE_W'(pmem_addr), LINE_W'(D_ADDR));
    pmem_resp = 1'b1;
    #1;
    chk("wb_d_resp", LINE_W'(d_resp), LINE_W'(1));
    chk("wb_i_resp", LINE_W'(i_resp), '0);
    tick();
    pmem_resp = 1'b0; d_write = 1'b0; d_wdata = '0;
    chk("wb_release", LINE_W'(dbg_state), LINE_W'(ARB_RELEASE));
    tick();

    // Asynchronous reset in the middle of a D grant
    d_read = 1'b1;
    tick();
    chk("ar_gnt", LINE_W'(dbg_state), LINE_W'(ARB_GNT_D));
    #2 rst_n = 1'b0; pmem_resp = 1'b1;
    #1;
    chk("ar_pmem_read", LINE_W'(pmem_read), '0);
    chk("ar_pmem_addr", LINE_W'(pmem_addr), '0);
    chk("ar_pmem_wdata", pmem_wdata, '0);
    chk("ar_d_resp", LINE_W'(d_resp), '0);
    chk("ar_busy", LINE_W'(arb_busy), '0);
    tick();
    rst_n = 1'b1; pmem_resp = 1'b0;
    #1;
    chk("ar_idle", LINE_W'(dbg_state), LINE_W'(ARB_IDLE));
    tick();
    chk("ar_regrant", LINE_W'(dbg_state), LINE_W'(ARB_GNT_D));
    chk("ar_regrant_read", LINE_W'(pmem_read), LINE_W'(1));
    pmem_resp = 1'b1;
    #1;
    chk("ar_regrant_resp", LINE_W'(d_resp), LINE_W'(1));
    tick();
    pmem_resp = 1'b0; d_read = 1'b0;
    tick();

    // Watchdog with TIMEOUT=8, then a late response
    i_read = 1'b1;
    tick();
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk($sformatf("wd_low_%0d", c), LINE_W'(arb_timeout), '0);
    end
    tick();
    chk("wd_rise", LINE_W'(arb_timeout), LINE_W'(1));
    tick(); tick();
    chk("wd_sticky", LINE_W'(arb_timeout), LINE_W'(1));
    chk("wd_still_gnt", LINE_W'(dbg_state), LINE_W'(ARB_GNT_I));
    pmem_resp = 1'b1;
    #1;
    chk("wd_late_resp", LINE_W'(i_resp), LINE_W'(1));
    tick();
    pmem_resp = 1'b0; i_read = 1'b0;
    tick();
    chk("wd_idle", LINE_W'(dbg_state), LINE_W'(ARB_IDLE));
    chk("wd_sticky_idle", LINE_W'(arb_timeout), LINE_W'(1));

    // Contention with both requests held
    do_reset();
    chk("ct_timeout_cleared", LINE_W'(arb_timeout), '0);
`ifdef ARB_RR_EN
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
    i_read = 1'b1; d_read = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      wait_gnt($sformatf("ct%0d_wait", g));
      exp_src = exp_q.pop_front();
      got_src = (dbg_state == ARB_GNT_D);
      chk($sformatf("ct%0d_src_d", g), LINE_W'(got_src), LINE_W'(exp_src));
      pmem_resp = 1'b1;
      #1;
      chk($sformatf("ct%0d_d_resp", g), LINE_W'(d_resp), LINE_W'(exp_src));
      chk($sformatf("ct%0d_i_resp", g), LINE_W'(i_resp), LINE_W'(!exp_src));
      tick();
      pmem_resp = 1'b0;
      if (g == 3) d_read = 1'b0;
    end
    i_read = 1'b0;
    tick(); tick();
    chk("ct_end_idle", LINE_W'(dbg_state), LINE_W'(ARB_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
